// File: rtl/alu_op_issuer.sv
// alu_op_issuer: buffers RV32I-style integer requests in a small FIFO, decodes
// the head entry onto the combinational ALU port one operation per cycle, and
// returns the registered result with its tag over a valid/ready response port.
module alu_op_issuer #(
  parameter int DEPTH = 2,
  parameter int TAG_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [2:0]       req_funct3,
  input  logic             req_funct7b5,
  input  logic             req_is_imm,
  input  logic             req_lui,
  input  logic [31:0]      req_a,
  input  logic [31:0]      req_b,
  input  logic [TAG_W-1:0] req_tag,
  output logic [3:0]       ALU_op,
  output logic [31:0]      alu_data1,
  output logic [31:0]      alu_data2,
  input  logic [31:0]      ALU_result,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [31:0]      rsp_result,
  output logic [TAG_W-1:0] rsp_tag,
  output logic             rsp_illegal,
  output logic [15:0]      issue_count
);

  localparam int PTR_W = $clog2(DEPTH);

  localparam logic [3:0] OP_ADD  = 4'b0000;
  localparam logic [3:0] OP_SUB  = 4'b0001;
  localparam logic [3:0] OP_SLL  = 4'b0010;
  localparam logic [3:0] OP_SLT  = 4'b0011;
  localparam logic [3:0] OP_SLTU = 4'b0100;
  localparam logic [3:0] OP_XOR  = 4'b0101;
  localparam logic [3:0] OP_SRL  = 4'b0110;
  localparam logic [3:0] OP_SRA  = 4'b0111;
  localparam logic [3:0] OP_OR   = 4'b1000;
  localparam logic [3:0] OP_AND  = 4'b1001;
  localparam logic [3:0] OP_PASS = 4'b1010;
  localparam logic [3:0] OP_NOP  = 4'b1111;

  // Decode result packing: {illegal, is_shift, opcode[3:0]}.
  function automatic logic [5:0] decode_op(
    input logic [2:0] funct3,
    input logic       funct7b5,
    input logic       is_imm,
    input logic       lui
  );
    logic [3:0] op;
    logic       shift;
    logic       illegal;
    op      = OP_NOP;
    shift   = 1'b0;
    illegal = 1'b0;
    if (lui) begin
      op = OP_PASS;
    end else begin
      case (funct3)
        3'b000: op = (funct7b5 && !is_imm) ? OP_SUB : OP_ADD;
        3'b001: begin
          shift = 1'b1;
          if (funct7b5) begin
            // SLL has no funct7b5 variant; the ALU sees a NOP for it.
            illegal = 1'b1;
            op      = OP_NOP;
          end else begin
            op = OP_SLL;
          end
        end
        3'b010: op = OP_SLT;
        3'b011: op = OP_SLTU;
        3'b100: op = OP_XOR;
        3'b101: begin
          shift = 1'b1;
          op    = funct7b5 ? OP_SRA : OP_SRL;
        end
        3'b110: op = OP_OR;
        3'b111: op = OP_AND;
        default: op = OP_NOP;
      endcase
    end
    return {illegal, shift, op};
  endfunction

  // Request storage (data only, no reset needed; validity comes from pointers)
  logic [2:0]       fifo_funct3_q [DEPTH];
  logic             fifo_f7b5_q   [DEPTH];
  logic             fifo_imm_q    [DEPTH];
  logic             fifo_lui_q    [DEPTH];
  logic [31:0]      fifo_a_q      [DEPTH];
  logic [31:0]      fifo_b_q      [DEPTH];
  logic [TAG_W-1:0] fifo_tag_q    [DEPTH];

  // Pointers carry an extra wrap bit so full and empty stay distinct.
  logic [PTR_W:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W:0] rd_ptr_q, rd_ptr_d;

  logic             rsp_valid_q,   rsp_valid_d;
  logic [31:0]      rsp_result_q,  rsp_result_d;
  logic [TAG_W-1:0] rsp_tag_q,     rsp_tag_d;
  logic             rsp_illegal_q, rsp_illegal_d;
  logic [15:0]      issue_count_q, issue_count_d;

  logic             empty_s;
  logic             full_s;
  logic             push_s;
  logic             issue_s;
  logic [PTR_W-1:0] wr_idx_s;
  logic [PTR_W-1:0] rd_idx_s;
  logic [5:0]       dec_s;

  assign wr_idx_s = wr_ptr_q[PTR_W-1:0];
  assign rd_idx_s = rd_ptr_q[PTR_W-1:0];
  assign empty_s  = (wr_ptr_q == rd_ptr_q);
  assign full_s   = (wr_ptr_q[PTR_W] != rd_ptr_q[PTR_W]) && (wr_idx_s == rd_idx_s);
  assign push_s   = req_valid && !full_s;
  assign issue_s  = !empty_s && (!rsp_valid_q || rsp_ready);
  assign dec_s    = decode_op(fifo_funct3_q[rd_idx_s], fifo_f7b5_q[rd_idx_s],
                              fifo_imm_q[rd_idx_s], fifo_lui_q[rd_idx_s]);

  // Drive the ALU from the head entry on issue cycles, NOP pattern otherwise
  always_comb begin
    ALU_op    = OP_NOP;
    alu_data1 = 32'd0;
    alu_data2 = 32'd0;
    if (issue_s) begin
      ALU_op    = dec_s[3:0];
      alu_data1 = fifo_a_q[rd_idx_s];
      alu_data2 = dec_s[4] ? {27'd0, fifo_b_q[rd_idx_s][4:0]} : fifo_b_q[rd_idx_s];
    end else begin
      ALU_op    = OP_NOP;
      alu_data1 = 32'd0;
      alu_data2 = 32'd0;
    end
  end

  // Next-state for pointers, response register and issue counter
  always_comb begin
    wr_ptr_d      = wr_ptr_q;
    rd_ptr_d      = rd_ptr_q;
    rsp_valid_d   = rsp_valid_q;
    rsp_result_d  = rsp_result_q;
    rsp_tag_d     = rsp_tag_q;
    rsp_illegal_d = rsp_illegal_q;
    issue_count_d = issue_count_q;
    if (push_s) begin
      wr_ptr_d = wr_ptr_q + (PTR_W+1)'(1);
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    if (issue_s) begin
      rd_ptr_d      = rd_ptr_q + (PTR_W+1)'(1);
      rsp_valid_d   = 1'b1;
      rsp_result_d  = dec_s[5] ? 32'd0 : ALU_result;
      rsp_tag_d     = fifo_tag_q[rd_idx_s];
      rsp_illegal_d = dec_s[5];
      issue_count_d = issue_count_q + 16'd1;
    end else if (rsp_ready) begin
      // Accepted with nothing new behind it: drop valid, keep the data.
      rsp_valid_d = 1'b0;
    end else begin
      rsp_valid_d = rsp_valid_q;
    end
  end

  // Write accepted requests at the FIFO tail
  always_ff @(posedge clk) begin
    if (push_s) begin
      fifo_funct3_q[wr_idx_s] <= req_funct3;
      fifo_f7b5_q[wr_idx_s]   <= req_funct7b5;
      fifo_imm_q[wr_idx_s]    <= req_is_imm;
      fifo_lui_q[wr_idx_s]    <= req_lui;
      fifo_a_q[wr_idx_s]      <= req_a;
      fifo_b_q[wr_idx_s]      <= req_b;
      fifo_tag_q[wr_idx_s]    <= req_tag;
    end
  end

  // Control state flops with asynchronous reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      rsp_valid_q   <= 1'b0;
      rsp_result_q  <= 32'd0;
      rsp_tag_q     <= '0;
      rsp_illegal_q <= 1'b0;
      issue_count_q <= 16'd0;
    end else begin
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      rsp_valid_q   <= rsp_valid_d;
      rsp_result_q  <= rsp_result_d;
      rsp_tag_q     <= rsp_tag_d;
      rsp_illegal_q <= rsp_illegal_d;
      issue_count_q <= issue_count_d;
    end
  end

  assign req_ready   = !full_s;
  assign rsp_valid   = rsp_valid_q;
  assign rsp_result  = rsp_result_q;
  assign rsp_tag     = rsp_tag_q;
  assign rsp_illegal = rsp_illegal_q;
  assign issue_count = issue_count_q;

endmodule

// File: tb/tb_alu_op_issuer.sv
// Self-checking bench for alu_op_issuer: a behavioural ALU answers the DUT's
// ALU port, an RV32I reference model fills a scoreboard queue at each request
// handshake, and a monitor pops and compares at every response handshake.
module tb_alu_op_issuer;

  localparam int DEPTH = 2;
  localparam int TAG_W = 4;

  logic             clk;
  logic             rst_n;
  logic             req_valid;
  logic             req_ready;
  logic [2:0]       req_funct3;
  logic             req_funct7b5;
  logic             req_is_imm;
  logic             req_lui;
  logic [31:0]      req_a;
  logic [31:0]      req_b;
  logic [TAG_W-1:0] req_tag;
  logic [3:0]       ALU_op;
  logic [31:0]      alu_data1;
  logic [31:0]      alu_data2;
  logic [31:0]      alu_result_s;
  logic             rsp_valid;
  logic             rsp_ready;
  logic [31:0]      rsp_result;
  logic [TAG_W-1:0] rsp_tag;
  logic             rsp_illegal;
  logic [15:0]      issue_count;

  int n_checks = 0;
  int n_errors = 0;

  typedef struct packed {
    logic [31:0]      res;
    logic [TAG_W-1:0] tag;
    logic             ill;
  } exp_t;

  exp_t exp_q[$];

  alu_op_issuer #(.DEPTH(DEPTH), .TAG_W(TAG_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_funct3(req_funct3), .req_funct7b5(req_funct7b5),
    .req_is_imm(req_is_imm), .req_lui(req_lui),
    .req_a(req_a), .req_b(req_b), .req_tag(req_tag),
    .ALU_op(ALU_op), .alu_data1(alu_data1), .alu_data2(alu_data2),
    .ALU_result(alu_result_s),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_result(rsp_result), .rsp_tag(rsp_tag), .rsp_illegal(rsp_illegal),
    .issue_count(issue_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural ALU; unknown opcodes return a marker so unmasked illegal results show up
  always_comb begin
    case (ALU_op)
      4'b0000: alu_result_s = alu_data1 + alu_data2;
      4'b0001: alu_result_s = alu_data1 - alu_data2;
      4'b0010: alu_result_s = alu_data1 << alu_data2[4:0];
      4'b0011: alu_result_s = {31'd0, $signed(alu_data1) < $signed(alu_data2)};
      4'b0100: alu_result_s = {31'd0, alu_data1 < alu_data2};
      4'b0101: alu_result_s = alu_data1 ^ alu_data2;
      4'b0110: alu_result_s = alu_data1 >> alu_data2[4:0];
      4'b0111: alu_result_s = $unsigned($signed(alu_data1) >>> alu_data2[4:0]);
      4'b1000: alu_result_s = alu_data1 | alu_data2;
      4'b1001: alu_result_s = alu_data1 & alu_data2;
      4'b1010: alu_result_s = alu_data2;
      default: alu_result_s = 32'hDEADBEEF;
    endcase
  end

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h, expected %h", tag, obs, exp);
    end
  endtask

  // RV32I reference: returns {illegal, result} straight from the request fields
  function automatic logic [32:0] ref_op(input logic [2:0] f3, input logic f7, input logic imm,
                                         input logic lui, input logic [31:0] a, input logic [31:0] b);
    logic [4:0] sh;
    sh = b[4:0];
    if (lui) return {1'b0, b};
    case (f3)
      3'b000: return {1'b0, (f7 && !imm) ? a - b : a + b};
      3'b001: return f7 ? {1'b1, 32'd0} : {1'b0, a << sh};
      3'b010: return {1'b0, 31'd0, $signed(a) < $signed(b)};
      3'b011: return {1'b0, 31'd0, a < b};
      3'b100: return {1'b0, a ^ b};
      3'b101: return f7 ? {1'b0, $unsigned($signed(a) >>> sh)} : {1'b0, a >> sh};
      3'b110: return {1'b0, a | b};
      default: return {1'b0, a & b};
    endcase
  endfunction

  // Drive one request, wait (bounded) for its handshake, record the expected response
  task automatic send(input logic [2:0] f3, input logic f7, input logic imm, input logic lui,
                      input logic [31:0] a, input logic [31:0] b, input logic [3:0] tag);
    logic        ok;
    logic [32:0] r;
    exp_t        e;
    req_funct3 = f3; req_funct7b5 = f7; req_is_imm = imm; req_lui = lui;
    req_a = a; req_b = b; req_tag = tag; req_valid = 1'b1;
    for (int i = 0; i < 50; i++) begin
      ok = req_ready;
      @(posedge clk);
      #1;
      if (ok) begin
        r = ref_op(f3, f7, imm, lui, a, b);
        e.res = r[31:0]; e.tag = tag; e.ill = r[32];
        exp_q.push_back(e);
        return;
      end
    end
    check_eq("send_timeout", 32'd1, 32'd0);
    req_valid = 1'b0;
  endtask

  task automatic cycles(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Scoreboard monitor: compare each accepted response against the queue head
  always @(negedge clk) begin
    exp_t e;
    if (rst_n && rsp_valid && rsp_ready) begin
      if (exp_q.size() == 0) begin
        check_eq("unexpected_rsp", 32'd1, 32'd0);
      end else begin
        e = exp_q.pop_front();
        check_eq("rsp_result", rsp_result, e.res);
        check_eq("rsp_tag", {28'd0, rsp_tag}, {28'd0, e.tag});
        check_eq("rsp_illegal", {31'd0, rsp_illegal}, {31'd0, e.ill});
      end
    end
  end

  task automatic check_reset_values(input string pfx);
    check_eq({pfx, "_req_ready"}, {31'd0, req_ready}, 32'd1);
    check_eq({pfx, "_rsp_valid"}, {31'd0, rsp_valid}, 32'd0);
    check_eq({pfx, "_rsp_result"}, rsp_result, 32'd0);
    check_eq({pfx, "_rsp_tag"}, {28'd0, rsp_tag}, 32'd0);
    check_eq({pfx, "_rsp_illegal"}, {31'd0, rsp_illegal}, 32'd0);
    check_eq({pfx, "_issue_count"}, {16'd0, issue_count}, 32'd0);
    check_eq({pfx, "_alu_op"}, {28'd0, ALU_op}, 32'hF);
    check_eq({pfx, "_alu_data1"}, alu_data1, 32'd0);
    check_eq({pfx, "_alu_data2"}, alu_data2, 32'd0);
  endtask

  logic [31:0]      held_res;
  logic [TAG_W-1:0] held_tag;

  initial begin
    rst_n = 1'b0; req_valid = 1'b0; rsp_ready = 1'b1;
    req_funct3 = 3'd0; req_funct7b5 = 1'b0; req_is_imm = 1'b0; req_lui = 1'b0;
    req_a = 32'd0; req_b = 32'd0; req_tag = 4'd0;
    #12;
    check_reset_values("reset");
    @(posedge clk); #1;
    rst_n = 1'b1;

    // ADD: issue-cycle opcode, two-edge latency, result
    send(3'b000, 1'b0, 1'b0, 1'b0, 32'd5, 32'd7, 4'd3);
    req_valid = 1'b0;
    check_eq("add_alu_op", {28'd0, ALU_op}, 32'h0);
    check_eq("add_lat_not_yet", {31'd0, rsp_valid}, 32'd0);
    cycles(1);
    check_eq("add_lat_valid", {31'd0, rsp_valid}, 32'd1);
    check_eq("add_result", rsp_result, 32'd12);

    // SUB, then the same encoding as OP-IMM which must add
    send(3'b000, 1'b1, 1'b0, 1'b0, 32'd5, 32'd7, 4'd4);
    req_valid = 1'b0;
    check_eq("sub_alu_op", {28'd0, ALU_op}, 32'h1);
    cycles(1);
    send(3'b000, 1'b1, 1'b1, 1'b0, 32'd5, 32'd7, 4'd5);
    req_valid = 1'b0;
    check_eq("addi_alu_op", {28'd0, ALU_op}, 32'h0);
    cycles(1);

    // SRA with masked shift amount
    send(3'b101, 1'b1, 1'b0, 1'b0, 32'h80000000, 32'h00000024, 4'd6);
    req_valid = 1'b0;
    check_eq("sra_alu_op", {28'd0, ALU_op}, 32'h7);
    check_eq("sra_data2", alu_data2, 32'd4);
    check_eq("sra_data1", alu_data1, 32'h80000000);
    cycles(1);

    // Illegal SLL with funct7b5
    send(3'b001, 1'b1, 1'b0, 1'b0, 32'h1234, 32'd3, 4'd7);
    req_valid = 1'b0;
    check_eq("ill_alu_op", {28'd0, ALU_op}, 32'hF);
    cycles(1);
    check_eq("ill_flag", {31'd0, rsp_illegal}, 32'd1);

    // LUI pass-through and a few other functions
    send(3'b111, 1'b0, 1'b0, 1'b1, 32'hFFFF, 32'hABCD0000, 4'd8);
    send(3'b010, 1'b0, 1'b0, 1'b0, 32'hFFFFFFFF, 32'd1, 4'd9);
    send(3'b011, 1'b0, 1'b0, 1'b0, 32'hFFFFFFFF, 32'd1, 4'd10);
    req_valid = 1'b0;
    cycles(3);
    check_eq("idle_nop", {28'd0, ALU_op}, 32'hF);

    // Backpressure: DEPTH+1 accepted, then full and response held stable
    rsp_ready = 1'b0;
    send(3'b100, 1'b0, 1'b0, 1'b0, 32'hF0F0, 32'h0FF0, 4'd11);
    send(3'b110, 1'b0, 1'b0, 1'b0, 32'hF000, 32'h000F, 4'd12);
    send(3'b011, 1'b0, 1'b1, 1'b0, 32'd3, 32'd9, 4'd13);
    req_valid = 1'b0;
    check_eq("bp_full", {31'd0, req_ready}, 32'd0);
    held_res = rsp_result;
    held_tag = rsp_tag;
    check_eq("bp_first_tag", {28'd0, held_tag}, 32'd11);
    cycles(3);
    check_eq("bp_hold_valid", {31'd0, rsp_valid}, 32'd1);
    check_eq("bp_hold_result", rsp_result, held_res);
    check_eq("bp_hold_tag", {28'd0, rsp_tag}, {28'd0, held_tag});
    check_eq("bp_still_full", {31'd0, req_ready}, 32'd0);
    rsp_ready = 1'b1;
    cycles(1);
    check_eq("bp_drain1_valid", {31'd0, rsp_valid}, 32'd1);
    check_eq("bp_drain1_tag", {28'd0, rsp_tag}, 32'd12);
    cycles(1);
    check_eq("bp_drain2_valid", {31'd0, rsp_valid}, 32'd1);
    check_eq("bp_drain2_tag", {28'd0, rsp_tag}, 32'd13);
    cycles(1);
    check_eq("bp_drain_done", {31'd0, rsp_valid}, 32'd0);

    // Stream 20 back-to-back requests from a fresh reset
    rst_n = 1'b0;
    #2;
    rst_n = 1'b1;
    exp_q.delete();
    cycles(1);
    for (int i = 0; i < 20; i++) begin
      check_eq("stream_ready", {31'd0, req_ready}, 32'd1);
      send(3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
           1'b0, $urandom, $urandom, 4'(i));
    end
    req_valid = 1'b0;
    cycles(3);
    check_eq("stream_count", {16'd0, issue_count}, 32'd20);
    check_eq("stream_drained", exp_q.size(), 32'd0);

    // Reset mid-operation with 2 queued entries and a pending response
    rsp_ready = 1'b0;
    send(3'b000, 1'b0, 1'b0, 1'b0, 32'd1, 32'd1, 4'd1);
    send(3'b000, 1'b0, 1'b0, 1'b0, 32'd2, 32'd2, 4'd2);
    send(3'b000, 1'b0, 1'b0, 1'b0, 32'd3, 32'd3, 4'd3);
    req_valid = 1'b0;
    check_eq("mid_pending", {31'd0, rsp_valid}, 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check_reset_values("midrst");
    exp_q.delete();
    @(posedge clk); #1;
    rst_n = 1'b1;
    rsp_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      cycles(1);
      check_eq("no_stale_rsp", {31'd0, rsp_valid}, 32'd0);
    end

    // issue_count wrap from 16'hFFFF
    @(negedge clk);
    force dut.issue_count_q = 16'hFFFF;
    #1;
    release dut.issue_count_q;
    check_eq("cnt_preset", {16'd0, issue_count}, 32'h0000FFFF);
    @(posedge clk); #1;
    send(3'b000, 1'b0, 1'b0, 1'b0, 32'd10, 32'd20, 4'd15);
    req_valid = 1'b0;
    cycles(3);
    check_eq("cnt_wrap", {16'd0, issue_count}, 32'd0);
    check_eq("final_drained", exp_q.size(), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
